// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the receive-side route-capability gate.
//   - cap_op encodings for host capability commands
//   - route request struct (sender UL id + destination port)
// The struct fields are sized for the largest supported configuration:
// up to 16 ports and up to 8-bit UL ids. Narrower instances zero-extend.
package gate_pkg;

    localparam int MAX_UL_ID_BITS = 8;
    localparam int MAX_PORT_BITS  = 4;

    localparam logic [1:0] CAP_GRANT    = 2'b00;
    localparam logic [1:0] CAP_REVOKE   = 2'b01;
    localparam logic [1:0] CAP_CLR_PORT = 2'b10;
    localparam logic [1:0] CAP_CLR_ALL  = 2'b11;

    typedef struct packed {
        logic [MAX_UL_ID_BITS-1:0] ul_id;
        logic [MAX_PORT_BITS-1:0]  port;
    } route_req_t;

endpackage

// File: rtl/gate_deny_cnt.sv
// gate_deny_cnt: bank of N saturating counters.
//   clk, rst   : clock, synchronous active-high reset (clears all counters)
//   inc        : increment strobe for the counter chosen by inc_sel
//   inc_sel    : counter to increment (values >= N are ignored)
//   rd_sel     : counter to read (values >= N read as zero)
//   rd_cnt     : registered read data, one cycle after rd_sel
module gate_deny_cnt #(
    parameter int N        = 4,
    parameter int SEL_BITS = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic [SEL_BITS-1:0] inc_sel,
    input  logic [SEL_BITS-1:0] rd_sel,
    output logic [CNT_BITS-1:0] rd_cnt
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic [CNT_BITS-1:0] cnt_r [N];
    logic [CNT_BITS-1:0] rd_s;

    // Counter update: increment the selected counter, holding at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= {CNT_BITS{1'b0}};
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (inc && (inc_sel == SEL_BITS'(i)) && (cnt_r[i] != CNT_MAX)) begin
                    cnt_r[i] <= cnt_r[i] + CNT_ONE;
                end
            end
        end
    end

    // Read mux: out-of-range selects return zero.
    always_comb begin
        rd_s = {CNT_BITS{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (rd_sel == SEL_BITS'(i)) begin
                rd_s = cnt_r[i];
            end else begin
                rd_s = rd_s;
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= {CNT_BITS{1'b0}};
        end else begin
            rd_cnt <= rd_s;
        end
    end

endmodule

// File: rtl/gate_recv_tbl.sv
// gate_recv_tbl: receive-side route-capability gate.
// A table of N_PORTS entries, each a bitmask of sender UL ids allowed to reach
// that port, is maintained by host commands and consulted for each routed
// request. Verdicts leave through a single output register stage.
//   aclk, areset          : clock, synchronous active-high reset
//   cap_valid/op/port/ul_id : host grant/revoke/clear-port/clear-all command
//   req_valid/ready/ul_id/port : incoming route request stream
//   rsp_valid/ready/grant/port : verdict stream (port echoes the request)
//   stat_port, stat_cnt   : per-port deny counter readback, 1-cycle latency
module gate_recv_tbl
    import gate_pkg::*;
#(
    parameter int N_PORTS    = 4,
    parameter int UL_ID_BITS = 3,
    parameter int PORT_BITS  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    parameter int CNT_BITS   = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cap_valid,
    input  logic [1:0]            cap_op,
    input  logic [PORT_BITS-1:0]  cap_port,
    input  logic [UL_ID_BITS-1:0] cap_ul_id,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [UL_ID_BITS-1:0] req_ul_id,
    input  logic [PORT_BITS-1:0]  req_port,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_grant,
    output logic [PORT_BITS-1:0]  rsp_port,
    input  logic [PORT_BITS-1:0]  stat_port,
    output logic [CNT_BITS-1:0]   stat_cnt
);

    localparam int N_UL = 2 ** UL_ID_BITS;

    logic [N_UL-1:0] table_r [N_PORTS];
    route_req_t      req_s;
    logic            accept_s;
    logic            port_ok_s;
    logic            hit_s;
    logic            deny_inc_s;

    // The output register can take a new verdict when empty or draining.
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept_s  = req_valid && req_ready;

    assign req_s.ul_id = MAX_UL_ID_BITS'(req_ul_id);
    assign req_s.port  = MAX_PORT_BITS'(req_port);

    // Table lookup; a port with no matching entry is out of range and denies.
    always_comb begin
        port_ok_s = 1'b0;
        hit_s     = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (req_s.port == MAX_PORT_BITS'(p)) begin
                port_ok_s = 1'b1;
                for (int u = 0; u < N_UL; u++) begin
                    if (req_s.ul_id == MAX_UL_ID_BITS'(u)) begin
                        hit_s = table_r[p][u];
                    end else begin
                        hit_s = hit_s;
                    end
                end
            end else begin
                port_ok_s = port_ok_s;
            end
        end
    end

    // Denials are counted at accept time, only for ports that exist.
    assign deny_inc_s = accept_s && port_ok_s && !hit_s;

    // Capability table; lookups in the same cycle see the pre-write contents.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int p = 0; p < N_PORTS; p++) begin
                table_r[p] <= {N_UL{1'b0}};
            end
        end else if (cap_valid) begin
            case (cap_op)
                CAP_GRANT: begin
                    for (int p = 0; p < N_PORTS; p++) begin
                        if (cap_port == PORT_BITS'(p)) begin
                            table_r[p][cap_ul_id] <= 1'b1;
                        end
                    end
                end
                CAP_REVOKE: begin
                    for (int p = 0; p < N_PORTS; p++) begin
                        if (cap_port == PORT_BITS'(p)) begin
                            table_r[p][cap_ul_id] <= 1'b0;
                        end
                    end
                end
                CAP_CLR_PORT: begin
                    for (int p = 0; p < N_PORTS; p++) begin
                        if (cap_port == PORT_BITS'(p)) begin
                            table_r[p] <= {N_UL{1'b0}};
                        end
                    end
                end
                CAP_CLR_ALL: begin
                    for (int p = 0; p < N_PORTS; p++) begin
                        table_r[p] <= {N_UL{1'b0}};
                    end
                end
                default: begin
                    for (int p = 0; p < N_PORTS; p++) begin
                        table_r[p] <= table_r[p];
                    end
                end
            endcase
        end
    end

    // Verdict output register; held while the consumer stalls.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rsp_valid <= 1'b0;
            rsp_grant <= 1'b0;
            rsp_port  <= {PORT_BITS{1'b0}};
        end else if (accept_s) begin
            rsp_valid <= 1'b1;
            rsp_grant <= port_ok_s && hit_s;
            rsp_port  <= req_port;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    gate_deny_cnt #(
        .N        (N_PORTS),
        .SEL_BITS (PORT_BITS),
        .CNT_BITS (CNT_BITS)
    ) u_deny_cnt (
        .clk     (aclk),
        .rst     (areset),
        .inc     (deny_inc_s),
        .inc_sel (req_port),
        .rd_sel  (stat_port),
        .rd_cnt  (stat_cnt)
    );

endmodule

// File: tb/tb_gate_recv_tbl.sv
// tb_gate_recv_tbl: self-checking bench for gate_recv_tbl, configured with
// 3 ports (so port index 3 is out of range), 3-bit UL ids and 4-bit counters.
// A behavioural model (permission array, verdict queue, saturating counts)
// predicts every output each cycle; directed scenarios add fixed expectations.
module tb_gate_recv_tbl;

    localparam int NP = 3;
    localparam int UB = 3;
    localparam int PB = 2;
    localparam int CB = 4;
    localparam int CMAX = 15;

    logic          aclk = 1'b0;
    logic          areset;
    logic          cap_valid;
    logic [1:0]    cap_op;
    logic [PB-1:0] cap_port;
    logic [UB-1:0] cap_ul_id;
    logic          req_valid;
    logic          req_ready;
    logic [UB-1:0] req_ul_id;
    logic [PB-1:0] req_port;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_grant;
    logic [PB-1:0] rsp_port;
    logic [PB-1:0] stat_port;
    logic [CB-1:0] stat_cnt;

    always #5 aclk = ~aclk;

    gate_recv_tbl #(
        .N_PORTS    (NP),
        .UL_ID_BITS (UB),
        .PORT_BITS  (PB),
        .CNT_BITS   (CB)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .cap_valid (cap_valid),
        .cap_op    (cap_op),
        .cap_port  (cap_port),
        .cap_ul_id (cap_ul_id),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ul_id (req_ul_id),
        .req_port  (req_port),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_grant (rsp_grant),
        .rsp_port  (rsp_port),
        .stat_port (stat_port),
        .stat_cnt  (stat_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    bit perm [NP][8];
    int cnt  [NP];
    typedef struct { bit g; int p; } verdict_t;
    verdict_t vq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) begin
            cnt[p] = 0;
            for (int u = 0; u < 8; u++) perm[p][u] = 1'b0;
        end
        vq.delete();
    endtask

    // Advance one clock with the currently driven inputs, updating the model
    // and comparing every output after the edge.
    task automatic cycle();
        bit acc;
        bit hit;
        int sexp;
        int rp;
        int cp;
        #1;
        if (areset) begin
            model_clear();
            sexp = 0;
        end else begin
            check("req_ready", {31'd0, req_ready}, {31'd0, (vq.size() == 0) || rsp_ready});
            acc  = req_valid && ((vq.size() == 0) || rsp_ready);
            sexp = (int'(stat_port) < NP) ? cnt[stat_port] : 0;
            if (vq.size() > 0 && rsp_ready) void'(vq.pop_front());
            if (acc) begin
                rp  = int'(req_port);
                hit = (rp < NP) ? perm[rp][req_ul_id] : 1'b0;
                vq.push_back('{hit, rp});
                if (rp < NP && !hit && cnt[rp] < CMAX) cnt[rp]++;
            end
            if (cap_valid) begin
                cp = int'(cap_port);
                case (cap_op)
                    2'd0: if (cp < NP) perm[cp][cap_ul_id] = 1'b1;
                    2'd1: if (cp < NP) perm[cp][cap_ul_id] = 1'b0;
                    2'd2: if (cp < NP) for (int u = 0; u < 8; u++) perm[cp][u] = 1'b0;
                    default: for (int p = 0; p < NP; p++) for (int u = 0; u < 8; u++) perm[p][u] = 1'b0;
                endcase
            end
        end
        @(posedge aclk);
        #1;
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, vq.size() != 0});
        if (vq.size() != 0) begin
            check("rsp_grant", {31'd0, rsp_grant}, {31'd0, vq[0].g});
            check("rsp_port", {30'd0, rsp_port}, 32'(vq[0].p));
        end
        check("stat_cnt", {28'd0, stat_cnt}, 32'(sexp));
    endtask

    task automatic set_req(input bit v, input int ul, input int port);
        req_valid = v;
        req_ul_id = UB'(ul);
        req_port  = PB'(port);
    endtask

    task automatic set_cap(input bit v, input int op, input int port, input int ul);
        cap_valid = v;
        cap_op    = 2'(op);
        cap_port  = PB'(port);
        cap_ul_id = UB'(ul);
    endtask

    initial begin
        model_clear();
        areset = 1'b1;
        set_cap(1'b0, 0, 0, 0);
        set_req(1'b0, 0, 0);
        rsp_ready = 1'b1;
        stat_port = 2'd0;
        cycle();
        cycle();
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_grant", {31'd0, rsp_grant}, 32'd0);
        check("reset_rsp_port", {30'd0, rsp_port}, 32'd0);
        check("reset_stat_cnt", {28'd0, stat_cnt}, 32'd0);
        areset = 1'b0;
        #1;
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);

        // Empty table denies; counter for port 1 reaches 1.
        set_req(1'b1, 2, 1);
        cycle();
        check("t1_valid", {31'd0, rsp_valid}, 32'd1);
        check("t1_grant", {31'd0, rsp_grant}, 32'd0);
        check("t1_port", {30'd0, rsp_port}, 32'd1);
        set_req(1'b0, 0, 0);
        stat_port = 2'd1;
        cycle();
        cycle();
        check("t1_cnt1", {28'd0, stat_cnt}, 32'd1);

        // Grant, other-UL deny, revoke.
        set_cap(1'b1, 0, 1, 2);
        cycle();
        set_cap(1'b0, 0, 0, 0);
        set_req(1'b1, 2, 1);
        cycle();
        check("t2_grant", {31'd0, rsp_grant}, 32'd1);
        set_req(1'b1, 3, 1);
        cycle();
        check("t2_other_ul", {31'd0, rsp_grant}, 32'd0);
        set_req(1'b0, 0, 0);
        set_cap(1'b1, 1, 1, 2);
        cycle();
        set_cap(1'b0, 0, 0, 0);
        set_req(1'b1, 2, 1);
        cycle();
        check("t2_revoked", {31'd0, rsp_grant}, 32'd0);

        // Same-cycle write and lookup: lookup sees the old table.
        set_cap(1'b1, 0, 1, 2);
        cycle();
        check("t3_same_cycle", {31'd0, rsp_grant}, 32'd0);
        set_cap(1'b0, 0, 0, 0);
        cycle();
        check("t3_next_cycle", {31'd0, rsp_grant}, 32'd1);

        // Backpressure: three requests, verdicts held then drained in order.
        rsp_ready = 1'b0;
        set_req(1'b1, 2, 1);
        cycle();
        set_req(1'b1, 0, 0);
        #1;
        check("t4_ready_low", {31'd0, req_ready}, 32'd0);
        cycle();
        check("t4_hold_grant", {31'd0, rsp_grant}, 32'd1);
        check("t4_hold_port", {30'd0, rsp_port}, 32'd1);
        cycle();
        check("t4_hold_port2", {30'd0, rsp_port}, 32'd1);
        rsp_ready = 1'b1;
        cycle();
        check("t4_drain1_port", {30'd0, rsp_port}, 32'd0);
        check("t4_drain1_grant", {31'd0, rsp_grant}, 32'd0);
        set_req(1'b1, 3, 1);
        cycle();
        check("t4_drain2_port", {30'd0, rsp_port}, 32'd1);
        check("t4_drain2_grant", {31'd0, rsp_grant}, 32'd0);
        set_req(1'b0, 0, 0);
        cycle();
        check("t4_empty", {31'd0, rsp_valid}, 32'd0);

        // Saturation on port 0; port 2 untouched.
        for (int i = 0; i < 20; i++) begin
            set_req(1'b1, 5, 0);
            cycle();
        end
        set_req(1'b0, 0, 0);
        stat_port = 2'd0;
        cycle();
        cycle();
        check("t5_sat", {28'd0, stat_cnt}, 32'd15);
        stat_port = 2'd2;
        cycle();
        cycle();
        check("t5_cnt2", {28'd0, stat_cnt}, 32'd0);

        // Out-of-range port: grant ignored, request denied, nothing counted.
        set_cap(1'b1, 0, 3, 0);
        cycle();
        set_cap(1'b0, 0, 0, 0);
        set_req(1'b1, 0, 3);
        cycle();
        check("t6_oor_grant", {31'd0, rsp_grant}, 32'd0);
        check("t6_oor_port", {30'd0, rsp_port}, 32'd3);
        set_req(1'b0, 0, 0);
        cycle();
        cycle();
        check("t6_cnt2", {28'd0, stat_cnt}, 32'd0);

        // Clear all after several grants.
        set_cap(1'b1, 0, 0, 1); cycle();
        set_cap(1'b1, 0, 1, 4); cycle();
        set_cap(1'b1, 0, 2, 7); cycle();
        set_cap(1'b0, 0, 0, 0);
        set_req(1'b1, 7, 2);
        cycle();
        check("t7_pre_clear", {31'd0, rsp_grant}, 32'd1);
        set_req(1'b0, 0, 0);
        set_cap(1'b1, 3, 0, 0);
        cycle();
        set_cap(1'b0, 0, 0, 0);
        set_req(1'b1, 1, 0); cycle(); check("t7_clr_p0", {31'd0, rsp_grant}, 32'd0);
        set_req(1'b1, 4, 1); cycle(); check("t7_clr_p1", {31'd0, rsp_grant}, 32'd0);
        set_req(1'b1, 7, 2); cycle(); check("t7_clr_p2", {31'd0, rsp_grant}, 32'd0);

        // Reset with a pending verdict discards it.
        rsp_ready = 1'b0;
        cycle();
        set_req(1'b0, 0, 0);
        areset = 1'b1;
        cycle();
        check("t8_discard", {31'd0, rsp_valid}, 32'd0);
        areset = 1'b0;
        rsp_ready = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            set_cap($urandom_range(0, 9) < 3, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7));
            if (cap_op == 2'd3 && $urandom_range(0, 3) != 0) cap_valid = 1'b0;
            set_req($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 3));
            rsp_ready = $urandom_range(0, 9) < 7;
            stat_port = PB'($urandom_range(0, 3));
            areset = ($urandom_range(0, 299) == 0);
            cycle();
        end
        areset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_recv_tbl.md
Name: gate_recv_tbl

Overview:
- Parametrised receive-side route-capability gate: generalises the single-entry-per-port check into a per-port bitmask of permitted sender UL ids.
- Host writes grant/revoke/clear operations; routed requests are checked against the table through a valid/ready stream.
- Sits between the network receive path and user-logic port demux; adds per-port saturating deny counters.

Parameters:
- N_PORTS, 4, number of receiving UL ports (1..16, need not be power of 2).
- UL_ID_BITS, 3, width of sender UL id; N_UL = 2**UL_ID_BITS bits per table entry.
- PORT_BITS, $clog2(N_PORTS) min 1, width of port index.
- CNT_BITS, 16, width of each deny counter.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- cap_valid  in  1  host capability command strobe (always accepted, no ready)
- cap_op  in  2  00 grant, 01 revoke, 10 clear port, 11 clear all
- cap_port  in  PORT_BITS  target port
- cap_ul_id  in  UL_ID_BITS  sender UL id for grant/revoke
- req_valid  in  1  route request valid
- req_ready  out  1  request accepted when valid&ready
- req_ul_id  in  UL_ID_BITS  sending UL id
- req_port  in  PORT_BITS  requested destination port
- rsp_valid  out  1  verdict valid
- rsp_ready  in  1  downstream ready
- rsp_grant  out  1  1 = permitted, 0 = denied
- rsp_port  out  PORT_BITS  port of the verdict (echo of req_port)
- stat_port  in  PORT_BITS  deny-counter select
- stat_cnt  out  CNT_BITS  deny counter of stat_port, registered, 1-cycle latency

Behaviour:
- Reset (areset=1 at posedge): table all zero (nothing permitted), all counters 0; rsp_valid=0, rsp_grant=0, rsp_port=0, stat_cnt=0. req_ready is combinational and goes 1 immediately after reset.
- Table: N_PORTS entries x N_UL bits, entry[p][u]=1 means UL u may send to port p.
- cap commands apply on the posedge where cap_valid=1:
  - grant sets entry[cap_port][cap_ul_id];
  - revoke clears it;
  - clear port zeroes entry[cap_port];
  - clear all zeroes the table.
  - cap_port >= N_PORTS: command ignored (clear all still applies).
- Lookup: a single output register stage. req_ready = !rsp_valid | rsp_ready.
- On accept (req_valid & req_ready):
  - rsp_valid <= 1;
  - rsp_port <= req_port;
  - rsp_grant <= (req_port < N_PORTS) & entry[req_port][req_ul_id].
- Latency 1 cycle; full throughput of one verdict per cycle when rsp_ready=1.
- rsp_valid drops only on rsp_ready without a new accept. rsp_* are held stable while rsp_valid & !rsp_ready.
- Same-cycle cap write and accept to the same entry: the lookup uses the pre-write table; the write is visible from the next accept.
- Deny counter[p] increments by 1 on each accepted request producing rsp_grant=0 for valid p, counted at accept time. It saturates at 2**CNT_BITS-1, never wraps. Out-of-range port denies are not counted.
- Clear-port and clear-all do not reset counters; only areset does.
- Reset mid-operation: a pending verdict is discarded (rsp_valid=0 next cycle), with no response for it.

Decomposition:
- Shared package (gate_pkg): cap_op encoding constants CAP_GRANT, CAP_REVOKE, CAP_CLR_PORT, CAP_CLR_ALL; typedef for the route request struct (ul_id, port).
- One natural sub-module: gate_deny_cnt, a saturating counter bank with increment-select and read-select, instantiated once with N_PORTS entries.
- Table and output register stay in the top module.

Test Plan:
- Reset then req (ul 2, port 1), rsp_ready=1 -> one cycle later rsp_valid=1, rsp_grant=0, rsp_port=1; counter[1]=1.
- Grant (port 1, ul 2), next cycle req (ul 2, port 1) -> rsp_grant=1. Req (ul 3, port 1) -> rsp_grant=0. Then revoke (port 1, ul 2) and req (ul 2, port 1) -> rsp_grant=0.
- Grant and req to the same entry in the same cycle -> rsp_grant=0; identical req on the next cycle -> rsp_grant=1.
- Backpressure: rsp_ready=0 with 3 back-to-back reqs -> req_ready=0 after the first accept; rsp_* held unchanged; releasing rsp_ready drains one verdict per cycle in order, with no loss or duplication.
- CNT_BITS=4: 20 denied reqs to port 0 -> stat_cnt=15 with stat_port=0; counter[2] stays 0.
- N_PORTS=3: req to port 3 -> rsp_grant=0, no counter change. Clear all after several grants -> every lookup denies.
